cci_can_issue_fsm: RTL and testbench
====================================

Name: cci_can_issue_fsm

Overview:
- Issue-throttling control for the CCI TX0 read-request channel.
- Converts the CCI almostfull back-pressure signal into a single can_issue permission.
- Read-request arbiters gate their grants with can_issue and report each accepted request back on issue.
- Allows a bounded number of requests after almostfull asserts, then blocks until almostfull has been deasserted long enough.

Parameters:
- MAX_SLACK, 4: maximum requests accepted after almostfull is first seen high; valid range 0..15.
- RESUME_DELAY, 1: consecutive almostfull-low cycles required to leave BLOCKED; valid range 1..15.
- CNT_W, 4: width of the slack and resume counters; must hold MAX_SLACK and RESUME_DELAY.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- resetb  input  1  reset; synchronous, active-low.
- almostfull  input  1  CCI TX0 almost-full back-pressure.
- issue  input  1  a request was issued this cycle; counted only while can_issue=1.
- can_issue  output  1  permission to issue a request this cycle.
- throttled  output  1  high when the state is THROTTLE or BLOCKED.
- err_blocked_issue  output  1  sticky error: issue seen while can_issue=0.

Behaviour:
- Interface: reset resetb, synchronous, active-low; clock clk.
- Registered state: state ∈ {OPEN, THROTTLE, BLOCKED}, slack_cnt, res_cnt, err flag.
- All outputs are decoded from registers only; there is no combinational path from almostfull or issue to any output.
- can_issue = (state != BLOCKED).
- throttled = (state != OPEN).
- err_blocked_issue = err flag.
- Reset (resetb=0 at an edge):
  - state <= BLOCKED, slack_cnt <= 0, res_cnt <= 0, err <= 0.
  - Hence can_issue=0, throttled=1, err_blocked_issue=0 while in reset.
  - Reset mid-operation aborts any count immediately.
- acc = issue & can_issue.
- OPEN:
  - almostfull=0: stay in OPEN.
  - almostfull=1: n = acc (0 or 1).
    - If n >= MAX_SLACK, go to BLOCKED with res_cnt <= 0.
    - Otherwise go to THROTTLE with slack_cnt <= n.
- THROTTLE:
  - almostfull=0: go to OPEN with slack_cnt <= 0.
  - almostfull=1: n = slack_cnt + acc.
    - If n >= MAX_SLACK, go to BLOCKED with res_cnt <= 0.
    - Otherwise stay in THROTTLE with slack_cnt <= n.
- BLOCKED:
  - almostfull=1: res_cnt <= 0.
  - almostfull=0 and res_cnt+1 == RESUME_DELAY: go to OPEN with slack_cnt <= 0, res_cnt <= 0.
  - almostfull=0 otherwise: res_cnt <= res_cnt+1.
- MAX_SLACK=0: almostfull in OPEN goes directly to BLOCKED, so at most one request is accepted in the cycle almostfull first rises.
- Latency: a state change is visible on can_issue in the cycle after the sampling edge.
  - A request may therefore be accepted in the same cycle almostfull first rises; it is counted toward MAX_SLACK.
- Error handling:
  - issue=1 while can_issue=0 sets err (sticky until reset).
  - Such an issue is not counted and does not change state.
- Counters saturate by construction and never wrap.
- Simultaneous almostfull fall and issue in THROTTLE: go to OPEN; the issue is not counted.

Test Plan (MAX_SLACK=4, RESUME_DELAY=1 unless stated):
- Reset, then release: hold resetb=0 for 3 cycles with almostfull=0, then release.
  - can_issue=0 and throttled=1 during reset and in the first cycle after release.
  - can_issue=1 and throttled=0 from the second cycle after release.
- Free flow: almostfull=0 with issue=1 for 20 cycles.
  - can_issue stays 1, throttled=0, err_blocked_issue=0 throughout.
- Slack exhaustion: almostfull rises and stays high, issue=1 every cycle.
  - can_issue=1 for exactly 4 accepted issues, counting the first almostfull cycle.
  - can_issue=0 from the next cycle on, with throttled=1.
- Partial slack: almostfull high for 2 issues, then low for 1 cycle, then high again with continuous issue.
  - State returns to OPEN and slack_cnt clears.
  - 4 further issues are accepted before can_issue=0.
- Blocked violation: in BLOCKED, drive issue=1 for one cycle.
  - err_blocked_issue=1 from the next cycle and stays 1 until resetb=0; slack count unaffected.
  - Then drop almostfull: can_issue=1 after 1 cycle.
- RESUME_DELAY=3: in BLOCKED, drive almostfull low 2 cycles, high 1 cycle, then low 3 cycles.
  - can_issue stays 0 until the 3 consecutive low cycles, then becomes 1 in the following cycle.

Source files
------------

// File: rtl/cci_can_issue_fsm.sv
// Issue throttle for the CCI TX0 read-request channel: turns almostfull back-pressure
// into a registered can_issue permission with bounded post-almostfull slack.
module cci_can_issue_fsm #(
  parameter int unsigned MAX_SLACK    = 4,
  parameter int unsigned RESUME_DELAY = 1,
  parameter int unsigned CNT_W        = 4
) (
  input  logic clk,
  input  logic resetb,
  input  logic almostfull,
  input  logic issue,
  output logic can_issue,
  output logic throttled,
  output logic err_blocked_issue
);

  localparam logic [1:0] StOpen     = 2'd0;
  localparam logic [1:0] StThrottle = 2'd1;
  localparam logic [1:0] StBlocked  = 2'd2;

  // One extra bit so the slack sum cannot wrap before the comparison.
  localparam logic [CNT_W:0]   MaxSlack    = (CNT_W + 1)'(MAX_SLACK);
  localparam logic [CNT_W-1:0] ResumeDelay = CNT_W'(RESUME_DELAY);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] slack_q, slack_d;
  logic [CNT_W-1:0] res_q, res_d;
  logic             err_q, err_d;

  logic             acc;
  logic [CNT_W:0]   open_n;
  logic [CNT_W:0]   slack_sum;
  logic [CNT_W-1:0] res_inc;

  assign can_issue         = (state_q != StBlocked);
  assign throttled         = (state_q != StOpen);
  assign err_blocked_issue = err_q;

  assign acc       = issue & can_issue;
  assign open_n    = {{CNT_W{1'b0}}, acc};
  assign slack_sum = {1'b0, slack_q} + {{CNT_W{1'b0}}, acc};
  assign res_inc   = res_q + {{(CNT_W-1){1'b0}}, 1'b1};

  always_comb begin
    state_d = state_q;
    slack_d = slack_q;
    res_d   = res_q;
    case (state_q)
      StOpen: begin
        if (almostfull) begin
          if (open_n >= MaxSlack) begin
            state_d = StBlocked;
            res_d   = '0;
          end else begin
            state_d = StThrottle;
            slack_d = open_n[CNT_W-1:0];
          end
        end
      end
      StThrottle: begin
        // A falling almostfull wins over a same-cycle issue; that issue is not counted.
        if (!almostfull) begin
          state_d = StOpen;
          slack_d = '0;
        end else if (slack_sum >= MaxSlack) begin
          state_d = StBlocked;
          res_d   = '0;
        end else begin
          slack_d = slack_sum[CNT_W-1:0];
        end
      end
      StBlocked: begin
        if (almostfull) begin
          res_d = '0;
        end else if (res_inc == ResumeDelay) begin
          state_d = StOpen;
          slack_d = '0;
          res_d   = '0;
        end else begin
          res_d = res_inc;
        end
      end
      default: begin
        state_d = StBlocked;
        slack_d = '0;
        res_d   = '0;
      end
    endcase
  end

  assign err_d = err_q | (issue & ~can_issue);

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state_q <= StBlocked;
      slack_q <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slack_q <= slack_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_cci_can_issue_fsm.sv
// Directed bench for cci_can_issue_fsm: default parameters, RESUME_DELAY=3 and MAX_SLACK=0.
module tb_cci_can_issue_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetb_a, af_a, issue_a, can_a, thr_a, err_a;
  logic resetb_b, af_b, issue_b, can_b, thr_b, err_b;
  logic resetb_c, af_c, issue_c, can_c, thr_c, err_c;

  int checks = 0;
  int errors = 0;

  cci_can_issue_fsm #(.MAX_SLACK(4), .RESUME_DELAY(1), .CNT_W(4)) u_a (
    .clk(clk), .resetb(resetb_a), .almostfull(af_a), .issue(issue_a),
    .can_issue(can_a), .throttled(thr_a), .err_blocked_issue(err_a)
  );

  cci_can_issue_fsm #(.MAX_SLACK(4), .RESUME_DELAY(3), .CNT_W(4)) u_b (
    .clk(clk), .resetb(resetb_b), .almostfull(af_b), .issue(issue_b),
    .can_issue(can_b), .throttled(thr_b), .err_blocked_issue(err_b)
  );

  cci_can_issue_fsm #(.MAX_SLACK(0), .RESUME_DELAY(1), .CNT_W(4)) u_c (
    .clk(clk), .resetb(resetb_c), .almostfull(af_c), .issue(issue_c),
    .can_issue(can_c), .throttled(thr_c), .err_blocked_issue(err_c)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic c, input logic t, input logic e);
    chk({tag, ".can_issue"}, can_a, c);
    chk({tag, ".throttled"}, thr_a, t);
    chk({tag, ".err"}, err_a, e);
  endtask

  initial begin
    resetb_a = 1'b0; af_a = 1'b0; issue_a = 1'b0;
    resetb_b = 1'b0; af_b = 1'b1; issue_b = 1'b0;
    resetb_c = 1'b0; af_c = 1'b0; issue_c = 1'b0;

    // Reset held for 3 cycles, then released
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_a("reset", 1'b0, 1'b1, 1'b0);
    end
    resetb_a = 1'b1;
    chk_a("rel0", 1'b0, 1'b1, 1'b0);
    tick();
    chk_a("rel1", 1'b1, 1'b0, 1'b0);

    // Free flow
    issue_a = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_a("free", 1'b1, 1'b0, 1'b0);
    end

    // Slack exhaustion: 4 accepted issues, first one in the almostfull-rise cycle
    af_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_a("slack_open", 1'b1, 1'b1, 1'b0);
    end
    tick();
    chk_a("slack_block", 1'b0, 1'b1, 1'b0);
    issue_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_a("slack_hold", 1'b0, 1'b1, 1'b0);
    end

    // Back to OPEN after one low cycle
    af_a = 1'b0;
    tick();
    chk_a("resume", 1'b1, 1'b0, 1'b0);

    // Partial slack, then a low cycle with a simultaneous issue clears the count
    af_a = 1'b1; issue_a = 1'b1;
    tick(); chk_a("part1", 1'b1, 1'b1, 1'b0);
    tick(); chk_a("part2", 1'b1, 1'b1, 1'b0);
    af_a = 1'b0;
    tick(); chk_a("part_open", 1'b1, 1'b0, 1'b0);
    af_a = 1'b1;
    // Idle throttle cycle must not consume slack
    tick(); chk_a("part_t1", 1'b1, 1'b1, 1'b0);
    issue_a = 1'b0;
    tick(); chk_a("part_idle", 1'b1, 1'b1, 1'b0);
    issue_a = 1'b1;
    tick(); chk_a("part_t2", 1'b1, 1'b1, 1'b0);
    tick(); chk_a("part_t3", 1'b1, 1'b1, 1'b0);
    tick(); chk_a("part_block", 1'b0, 1'b1, 1'b0);

    // Blocked violation: sticky error, no state change
    tick(); chk_a("viol", 1'b0, 1'b1, 1'b1);
    issue_a = 1'b0;
    tick(); chk_a("viol_hold", 1'b0, 1'b1, 1'b1);
    af_a = 1'b0;
    tick(); chk_a("viol_resume", 1'b1, 1'b0, 1'b1);
    af_a = 1'b1; issue_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_a("viol_slack", 1'b1, 1'b1, 1'b1);
    end
    tick(); chk_a("viol_reblock", 1'b0, 1'b1, 1'b1);
    issue_a = 1'b0;
    resetb_a = 1'b0;
    tick(); chk_a("rst_clr", 1'b0, 1'b1, 1'b0);
    resetb_a = 1'b1; af_a = 1'b0;
    tick(); chk_a("rst_resume", 1'b1, 1'b0, 1'b0);

    // RESUME_DELAY=3: low 2, high 1, low 3
    resetb_b = 1'b1;
    tick(); chk("rd3.hi", can_b, 1'b0);
    af_b = 1'b0;
    tick(); chk("rd3.lo1", can_b, 1'b0);
    tick(); chk("rd3.lo2", can_b, 1'b0);
    af_b = 1'b1;
    tick(); chk("rd3.hi2", can_b, 1'b0);
    af_b = 1'b0;
    tick(); chk("rd3.l1", can_b, 1'b0);
    tick(); chk("rd3.l2", can_b, 1'b0);
    tick(); chk("rd3.open", can_b, 1'b1);
    chk("rd3.thr", thr_b, 1'b0);
    chk("rd3.err", err_b, 1'b0);

    // MAX_SLACK=0: almostfull in OPEN blocks immediately
    resetb_c = 1'b1;
    tick(); chk("ms0.open", can_c, 1'b1);
    af_c = 1'b1; issue_c = 1'b1;
    tick(); chk("ms0.block", can_c, 1'b0);
    chk("ms0.thr", thr_c, 1'b1);
    issue_c = 1'b0;
    tick(); chk("ms0.err", err_c, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
